// File: rtl/scan_sram_pkg.sv
// scan_sram_pkg: shared FSM encoding and packet field offsets for the scan SRAM controller
package scan_sram_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;
   localparam int CSB_BIT = 0;
   localparam int WEB_BIT = 1;
   localparam int WMASK_LSB = 2;
   function automatic int din_lsb(input int wmask_w);
      return WMASK_LSB + wmask_w;
   endfunction
   function automatic int addr_lsb(input int data_w, input int wmask_w);
      return din_lsb(wmask_w) + data_w;
   endfunction
   function automatic int id_lsb(input int addr_w, input int data_w, input int wmask_w);
      return addr_lsb(data_w, wmask_w) + addr_w;
   endfunction
endpackage

// File: rtl/scan_shift_reg.sv
// scan_shift_reg: serial packet register with MSB-first shift and parallel din-field load
module scan_shift_reg #(
   parameter int PKT_W = 58,
   parameter int DATA_W = 32,
   parameter int DIN_LSB = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             shift,
   input  logic             scan_in,
   input  logic             load,
   input  logic [DATA_W-1:0] din,
   output logic [PKT_W-1:0] pkt
);
   localparam logic [PKT_W-1:0] RST_VAL = {{(PKT_W-2){1'b0}}, 2'b11};
   // reset to an idle no-op packet; capture beats shift; otherwise hold (frozen)
   always_ff @(posedge clk)
      if (!resetn) pkt <= RST_VAL;
      else if (load) pkt[DIN_LSB +: DATA_W] <= din;
      else if (shift) pkt <= {pkt[PKT_W-2:0], scan_in};
endmodule

// File: rtl/scan_sram_ctrl.sv
// scan_sram_ctrl: scan-loaded packet drives one SRAM access per load edge, read data captured back
module scan_sram_ctrl
   import scan_sram_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int WMASK_W = 4,
   parameter int ID_W = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               scan_en,
   input  logic               scan_in,
   output logic               scan_out,
   input  logic               sram_load,
   input  logic               global_csb,
   output logic [ID_W-1:0]    sram_sel,
   output logic               sram_csb,
   output logic               sram_web,
   output logic [WMASK_W-1:0] sram_wmask,
   output logic [ADDR_W-1:0]  sram_addr,
   output logic [DATA_W-1:0]  sram_din,
   input  logic [DATA_W-1:0]  sram_dout,
   output logic               busy
);
   localparam int PKT_W = ID_W + ADDR_W + DATA_W + WMASK_W + 2;
   localparam int DIN_LSB = din_lsb(WMASK_W);
   localparam int ADDR_LSB = addr_lsb(DATA_W, WMASK_W);
   localparam int ID_LSB = id_lsb(ADDR_W, DATA_W, WMASK_W);
   state_t state, state_nxt;
   logic load_q, rd_q, load_edge, eff_csb, shift;
   logic [PKT_W-1:0] pkt;
   assign load_edge = sram_load & ~load_q;
   assign eff_csb = pkt[CSB_BIT] | global_csb;
   assign shift = (state == IDLE) & scan_en & ~load_edge;
   assign busy = state != IDLE;
   assign scan_out = pkt[PKT_W-1];
   assign sram_sel = pkt[ID_LSB +: ID_W];
   assign sram_addr = pkt[ADDR_LSB +: ADDR_W];
   assign sram_din = pkt[DIN_LSB +: DATA_W];
   assign sram_wmask = pkt[WMASK_LSB +: WMASK_W];
   assign sram_web = pkt[WEB_BIT];
   scan_shift_reg #(.PKT_W(PKT_W), .DATA_W(DATA_W), .DIN_LSB(DIN_LSB)) u_pkt (
      .clk(clk), .resetn(resetn), .shift(shift), .scan_in(scan_in),
      .load(state == CAPTURE), .din(sram_dout), .pkt(pkt)
   );
   // state register, load history, and latch whether the issued op was an effective read
   always_ff @(posedge clk)
      if (!resetn) begin
         state <= IDLE;
         load_q <= 1'b0;
         rd_q <= 1'b0;
      end else begin
         state <= state_nxt;
         load_q <= sram_load;
         if (state == ISSUE) rd_q <= ~eff_csb & pkt[WEB_BIT];
      end
   // next state; chip select only ever asserted in ISSUE
   always_comb begin
      state_nxt = state;
      sram_csb = 1'b1;
      case (state)
         IDLE:    state_nxt = load_edge ? ISSUE : IDLE;
         ISSUE: begin
            sram_csb = eff_csb;
            state_nxt = WAIT;
         end
         WAIT:    state_nxt = rd_q ? CAPTURE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_scan_sram_ctrl.sv
// tb_scan_sram_ctrl: directed scoreboard bench for scan_sram_ctrl with a behavioural SRAM
module tb_scan_sram_ctrl;
   logic clk = 0, resetn = 0, scan_en = 0, scan_in = 0, sram_load = 0, global_csb = 0;
   logic scan_out, sram_csb, sram_web, busy;
   logic [3:0] sram_sel, sram_wmask;
   logic [15:0] sram_addr;
   logic [31:0] sram_din, sram_dout = 0;
   logic [31:0] mem [0:255];
   logic [56:0] op_q [$];
   logic [57:0] exp_q [$];
   int checks = 0, errors = 0;

   scan_sram_ctrl dut (
      .clk(clk), .resetn(resetn), .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
      .sram_load(sram_load), .global_csb(global_csb), .sram_sel(sram_sel), .sram_csb(sram_csb),
      .sram_web(sram_web), .sram_wmask(sram_wmask), .sram_addr(sram_addr), .sram_din(sram_din),
      .sram_dout(sram_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   // behavioural SRAM: write with byte mask, registered read data held until next read
   always @(posedge clk)
      if (!sram_csb) begin
         if (!sram_web) begin
            for (int b = 0; b < 4; b++)
               if (sram_wmask[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_din[8*b +: 8];
         end else sram_dout <= mem[sram_addr[7:0]];
      end

   // every chip-select cycle must match the next expected operation
   always @(negedge clk)
      if (!sram_csb) begin
         checks++;
         if (op_q.size() == 0) begin
            errors++;
            $error("FAIL csb_unexpected observed=csb_low required=no_op");
         end else begin
            automatic logic [56:0] e = op_q.pop_front();
            assert ({sram_sel, sram_addr, sram_din, sram_wmask, sram_web} === e)
            else begin
               errors++;
               $error("FAIL op_fields observed=%h required=%h", {sram_sel, sram_addr, sram_din, sram_wmask, sram_web}, e);
            end
         end
      end

   function automatic logic [57:0] pk(input logic [3:0] id, input logic [15:0] a, input logic [31:0] d,
                                      input logic [3:0] m, input logic web, input logic csb);
      return {id, a, d, m, web, csb};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h required=%h", tag, obs, exp);
      end
   endtask

   task automatic shift_in(input logic [57:0] p);
      for (int i = 57; i >= 0; i--) begin
         scan_en = 1;
         scan_in = p[i];
         tick;
      end
      scan_en = 0;
      scan_in = 0;
   endtask

   task automatic shift_out(input string tag);
      logic [57:0] got, e;
      for (int i = 57; i >= 0; i--) begin
         got[i] = scan_out;
         scan_en = 1;
         scan_in = 0;
         tick;
      end
      scan_en = 0;
      e = exp_q.pop_front();
      checks++;
      assert (got === e)
      else begin
         errors++;
         $error("FAIL %s observed=%h required=%h", tag, got, e);
      end
   endtask

   task automatic run_op(input int n, output int nb, output int nc);
      nb = 0;
      nc = 0;
      for (int i = 0; i < n; i++) begin
         tick;
         nb += busy;
         nc += !sram_csb;
      end
   endtask

   initial begin
      int nb, nc;
      logic [57:0] p;
      for (int i = 0; i < 256; i++) mem[i] = 0;
      tick;
      tick;
      chk("rst_csb", sram_csb, 1);
      chk("rst_web", sram_web, 1);
      chk("rst_busy", busy, 0);
      chk("rst_scan_out", scan_out, 0);
      chk("rst_sel", sram_sel, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_din", sram_din, 0);
      chk("rst_wmask", sram_wmask, 0);
      resetn = 1;
      tick;
      // write 0xDEADBEEF to 0x0010
      p = pk(1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 0);
      shift_in(p);
      op_q.push_back(p[57:1]);
      sram_load = 1;
      run_op(6, nb, nc);
      sram_load = 0;
      chk("wr_busy_cycles", nb, 2);
      chk("wr_csb_cycles", nc, 1);
      chk("wr_pkt_kept", sram_din, 32'hDEADBEEF);
      tick;
      // read back, then shift the captured packet out
      p = pk(1, 16'h0010, 0, 0, 1, 0);
      shift_in(p);
      op_q.push_back(p[57:1]);
      exp_q.push_back(pk(1, 16'h0010, 32'hDEADBEEF, 0, 1, 0));
      sram_load = 1;
      run_op(6, nb, nc);
      sram_load = 0;
      chk("rd_busy_cycles", nb, 3);
      chk("rd_csb_cycles", nc, 1);
      chk("rd_captured_din", sram_din, 32'hDEADBEEF);
      shift_out("rd_roundtrip");
      tick;
      // global_csb blocks the read
      p = pk(1, 16'h0010, 32'h12345678, 0, 1, 0);
      shift_in(p);
      global_csb = 1;
      sram_load = 1;
      run_op(6, nb, nc);
      sram_load = 0;
      global_csb = 0;
      chk("gcsb_busy_cycles", nb, 2);
      chk("gcsb_csb_cycles", nc, 0);
      chk("gcsb_din_kept", sram_din, 32'h12345678);
      tick;
      // load edge beats scan_en; a second edge while busy is dropped
      p = pk(2, 16'h0020, 32'hCAFEF00D, 4'h3, 0, 0);
      shift_in(p);
      op_q.push_back(p[57:1]);
      scan_en = 1;
      scan_in = 1;
      sram_load = 1;
      run_op(1, nb, nc);
      scan_en = 0;
      sram_load = 0;
      run_op(1, nb, nb);
      sram_load = 1;
      run_op(1, nb, nb);
      sram_load = 0;
      run_op(5, nb, nb);
      chk("dual_csb_cycles", nc, 1);
      chk("dual_no_shift_addr", sram_addr, 16'h0020);
      chk("dual_no_shift_din", sram_din, 32'hCAFEF00D);
      chk("dual_no_shift_sel", sram_sel, 2);
      // reset during WAIT of a read aborts capture
      p = pk(1, 16'h0010, 32'h00000055, 0, 1, 0);
      shift_in(p);
      op_q.push_back(p[57:1]);
      sram_load = 1;
      tick;
      tick;
      chk("abort_in_wait", busy, 1);
      resetn = 0;
      sram_load = 0;
      tick;
      chk("abort_busy", busy, 0);
      chk("abort_csb", sram_csb, 1);
      chk("abort_web", sram_web, 1);
      chk("abort_din", sram_din, 0);
      resetn = 1;
      run_op(4, nb, nc);
      chk("abort_no_capture", sram_din, 0);
      chk("abort_idle", nb, 0);
      // load held high for 10 cycles gives one operation
      p = pk(3, 16'h0030, 32'h0BADF00D, 4'h1, 0, 0);
      shift_in(p);
      op_q.push_back(p[57:1]);
      sram_load = 1;
      run_op(10, nb, nc);
      sram_load = 0;
      tick;
      chk("held_csb_cycles", nc, 1);
      chk("held_busy_cycles", nb, 2);
      chk("ops_all_seen", op_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/scan_sram_ctrl.md
SCAN_SRAM_CTRL -- requirements
Module: scan_sram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, SRAM address width.
REQ-002 Parameter DATA_W, default 32, SRAM data width.
REQ-003 Parameter WMASK_W, default 4, write-mask width.
REQ-004 Parameter ID_W, default 4, SRAM select width; PKT_W = ID_W+ADDR_W+DATA_W+WMASK_W+2 (58 at defaults).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 resetn  in  1  reset, synchronous and active-low.
REQ-007 scan_en  in  1  shift enable for packet register.
REQ-008 scan_in  in  1  serial packet input, MSB first.
REQ-009 scan_out  out  1  serial output = packet register MSB.
REQ-010 sram_load  in  1  level; rising edge launches one SRAM operation.
REQ-011 global_csb  in  1  high blocks all SRAM chip-selects.
REQ-012 sram_sel  out  ID_W  target SRAM index.
REQ-013 sram_csb  out  1  active-low chip select to selected macro.
REQ-014 sram_web  out  1  active-low write enable.
REQ-015 sram_wmask  out  WMASK_W  byte write mask.
REQ-016 sram_addr  out  ADDR_W  address.
REQ-017 sram_din  out  DATA_W  write data.
REQ-018 sram_dout  in  DATA_W  read data from selected macro, valid one cycle after csb-low cycle.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 Packet layout: [PKT_W-1 -: ID_W] id, then addr, then din, then wmask, then web at bit 1, csb at bit 0.
REQ-021 In IDLE with scan_en=1 and no load edge, pkt <= {pkt[PKT_W-2:0], scan_in} every cycle.
REQ-022 Load edge = sram_load high this cycle and low previous cycle (one registered copy).
REQ-023 FSM states IDLE, ISSUE, WAIT, CAPTURE.
REQ-024 IDLE -> ISSUE on load edge; load edge wins over scan_en in the same cycle (no shift that cycle).
REQ-025 ISSUE (1 cycle): sram_csb = pkt.csb | global_csb; web/wmask/addr/din/sel driven from pkt; -> WAIT.
REQ-026 WAIT (1 cycle): sram_csb=1; -> CAPTURE if operation was an effective read (effective csb=0, web=1), else -> IDLE.
REQ-027 CAPTURE (1 cycle): pkt.din field <= sram_dout, all other fields unchanged; -> IDLE.
REQ-028 Writes and blocked/no-op operations leave pkt unchanged.
REQ-029 sram_csb SHALL be 1 in every state except ISSUE; sram_sel/addr/din/wmask/web continuously reflect pkt.
REQ-030 While busy, scan_en and further load edges ignored (pkt frozen, edges not queued).
REQ-031 Operation latency: load edge cycle N -> csb low cycle N+1 -> read data in pkt at end of N+3; busy deasserts at N+3 (read) or N+2 (write).
REQ-032 Packet round-trip: after capture, PKT_W scan_en cycles shift the full packet out on scan_out.

Reset
REQ-033 resetn=0 at a clock edge: state=IDLE, pkt=0 except csb bit=1 and web bit=1, load history=0; takes effect mid-operation, aborting it.
REQ-034 Post-reset outputs: sram_csb=1, sram_web=1, busy=0, scan_out=0, sram_sel/addr/din/wmask=0.

Structure
REQ-035 State encoding enum and packet field offset constants SHALL live in shared package scan_sram_pkg.
REQ-036 Serial packet register SHALL be sub-module scan_shift_reg (shift, parallel din-field load, freeze).
REQ-037 No combinational path from scan_in or sram_dout to any output.

Verification
REQ-038 Write: shift id=1, addr=0x0010, din=0xDEADBEEF, wmask=0xF, web=0, csb=0; load -> one cycle csb=0,web=0,addr=0x0010, busy 2 cycles.
REQ-039 Read: shift id=1, addr=0x0010, web=1, csb=0; load; model returns 0xDEADBEEF -> 58 shift cycles output din field 0xDEADBEEF, others as shifted in.
REQ-040 global_csb=1 during read load -> sram_csb stays 1, pkt unchanged, busy 2 cycles.
REQ-041 scan_en and load edge same cycle, plus second load edge while busy -> no shift, exactly one csb pulse.
REQ-042 resetn low in WAIT of a read -> next cycle IDLE, csb=1, web=1, pkt din=0, no capture.
REQ-043 Load held high 10 cycles -> exactly one operation.
